// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types and constants for the instruction-fetch stage.
//   state_t    : fetch FSM states (IDLE, WAIT)
//   ALIGN_MASK : low pc bits that must be zero for a word-aligned fetch
//   entry_t    : {pc, instr} queue entry at the default 32/32 widths, for
//                consumers that do not re-parameterise the stage
package ifetch_pkg;

    localparam int IF_ADDR_W = 32;
    localparam int IF_DATA_W = 32;

    localparam logic [1:0] ALIGN_MASK = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    typedef struct packed {
        logic [IF_ADDR_W-1:0] pc;
        logic [IF_DATA_W-1:0] instr;
    } entry_t;

endpackage

// File: rtl/ifetch_queue.sv
// fetch_queue: synchronous FIFO holding fetched {pc, instr} entries.
//   clk, rst    : clock, synchronous active-high reset
//   push, wdata : write an entry (ignored when full unless popping too)
//   pop         : remove the head entry (ignored when empty)
//   clear       : empty the queue; wins over push and pop
//   rdata       : head entry (valid when !empty)
//   count       : number of entries, 0..DEPTH
//   empty, full : status flags derived from count
module fetch_queue #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    input  logic                     clear,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = DEPTH[PTR_W:0];

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [PTR_W-1:0]            wptr, rptr;
    logic                        do_push, do_pop;

    assign empty = (count == '0);
    assign full  = (count == DEPTH_C);
    assign rdata = mem[rptr];

    // A push into a full queue is only legal when the head leaves the same
    // cycle; in that case wptr == rptr and the head has already been read.
    assign do_push = push & (~full | pop);
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem   <= '0;
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (clear) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                mem[wptr] <= wdata;
                wptr      <= wptr + 1'b1;   // power-of-2 depth: natural wrap
            end
            if (do_pop)
                rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ifetch.sv
// ifetch: instruction-fetch stage between the PC generator and decode.
//   clk, rst               : clock, synchronous active-high reset
//   pc, pc_valid, pc_ready : fetch address handshake from the PC generator
//   mem_req, mem_addr      : single outstanding read to instruction memory
//   mem_ack, mem_rdata     : read completion and data
//   flush                  : discard queued and in-flight fetches
//   instr_valid/instr/instr_pc/instr_ready : queue head toward decode
//   misalign               : one-cycle pulse for an accepted unaligned pc
module ifetch
    import ifetch_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc,
    input  logic              pc_valid,
    output logic              pc_ready,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              flush,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              instr_ready,
    output logic              misalign
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = DEPTH[CNT_W-1:0];

    // Same layout as ifetch_pkg::entry_t, at this instance's widths.
    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] instr;
    } q_entry_t;

    state_t           state;
    logic             drop;
    logic             accept, aligned;
    logic             q_push, q_pop;
    logic             q_empty, q_full;
    logic [CNT_W-1:0] q_count;
    q_entry_t         q_wdata, q_rdata;

    // Only one fetch is ever in flight, so a free slot at accept time is
    // still free when its data returns: count is the only reservation.
    assign pc_ready = (state == IDLE) & ~flush & (q_count < DEPTH_C);
    assign accept   = pc_valid & pc_ready;
    assign aligned  = ((pc[1:0] & ALIGN_MASK) == 2'b00);

    assign q_pop   = instr_valid & instr_ready;
    assign q_push  = (state == WAIT) & mem_ack & ~drop & ~flush & (~q_full | q_pop);
    assign q_wdata = '{pc: mem_addr, instr: mem_rdata};

    fetch_queue #(
        .DEPTH (DEPTH),
        .WIDTH (ADDR_W + DATA_W)
    ) u_queue (
        .clk   (clk),
        .rst   (rst),
        .push  (q_push),
        .wdata (q_wdata),
        .pop   (q_pop),
        .clear (flush),
        .rdata (q_rdata),
        .count (q_count),
        .empty (q_empty),
        .full  (q_full)
    );

    assign instr_valid = ~q_empty;
    assign instr       = q_rdata.instr;
    assign instr_pc    = q_rdata.pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            mem_req  <= 1'b0;
            mem_addr <= '0;
            drop     <= 1'b0;
            misalign <= 1'b0;
        end else begin
            misalign <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (!aligned) begin
                            misalign <= 1'b1;
                        end else begin
                            mem_addr <= pc;
                            mem_req  <= 1'b1;
                            state    <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (mem_ack) begin
                        // Completion retires any pending discard.
                        mem_req <= 1'b0;
                        drop    <= 1'b0;
                        state   <= IDLE;
                    end else if (flush) begin
                        // Memory cannot be cancelled; let it finish, drop the data.
                        drop <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch.sv
module tb_ifetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc = '0;
    logic        pc_valid = 1'b0;
    logic        pc_ready;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        flush = 1'b0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b0;
    logic        misalign;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];
    logic [63:0] mon_exp;

    ifetch #(.DEPTH(2), .ADDR_W(32), .DATA_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .pc          (pc),
        .pc_valid    (pc_valid),
        .pc_ready    (pc_ready),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .flush       (flush),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready),
        .misalign    (misalign)
    );

    always #5 clk = ~clk;

    // Monitor: every pop the DUT performs is compared against the scoreboard.
    always @(negedge clk) begin
        if (!rst && instr_valid === 1'b1 && instr_ready === 1'b1) begin
            checks = checks + 1;
            if (exp_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL pop_unexpected got pc=%h instr=%h expected no entry", instr_pc, instr);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({instr_pc, instr} !== mon_exp) begin
                    errors = errors + 1;
                    $display("FAIL pop_order got pc=%h instr=%h expected pc=%h instr=%h",
                             instr_pc, instr, mon_exp[63:32], mon_exp[31:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one fetch: wait for pc_ready, accept, hold the request for
    // ack_delay cycles, then ack. Returns right after the ack edge.
    task automatic do_fetch(input logic [31:0] addr, input logic [31:0] data,
                            input int ack_delay, input bit expect_push);
        int n;
        pc = addr;
        pc_valid = 1'b1;
        n = 0;
        while (pc_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks = checks + 1;
        if (pc_ready !== 1'b1) begin
            errors = errors + 1;
            $display("FAIL accept_timeout got pc_ready=%b expected 1 within 20 cycles", pc_ready);
            pc_valid = 1'b0;
            return;
        end
        tick();
        pc_valid = 1'b0;
        check("req_asserted", {63'd0, mem_req}, 64'd1);
        check("req_addr", {32'd0, mem_addr}, {32'd0, addr});
        repeat (ack_delay) tick();
        mem_ack = 1'b1;
        mem_rdata = data;
        if (expect_push) exp_q.push_back({addr, data});
        tick();
        mem_ack = 1'b0;
    endtask

    initial begin
        // ---- 1: reset state and a basic fetch ----
        tick();
        tick();
        check("rst_mem_req", {63'd0, mem_req}, 64'd0);
        check("rst_mem_addr", {32'd0, mem_addr}, 64'd0);
        check("rst_instr_valid", {63'd0, instr_valid}, 64'd0);
        check("rst_instr", {32'd0, instr}, 64'd0);
        check("rst_instr_pc", {32'd0, instr_pc}, 64'd0);
        check("rst_misalign", {63'd0, misalign}, 64'd0);
        rst = 1'b0;
        check("idle_pc_ready", {63'd0, pc_ready}, 64'd1);
        do_fetch(32'h0, 32'h2008_0005, 2, 1'b1);
        check("t1_instr_valid", {63'd0, instr_valid}, 64'd1);
        check("t1_head", {instr_pc, instr}, {32'h0, 32'h2008_0005});
        check("t1_req_drop", {63'd0, mem_req}, 64'd0);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        check("t1_empty", {63'd0, instr_valid}, 64'd0);

        // ---- 2: fill, back-pressure, FIFO order ----
        do_fetch(32'h4, 32'h1111_1111, 0, 1'b1);
        do_fetch(32'h8, 32'h2222_2222, 1, 1'b1);
        pc = 32'hC;
        pc_valid = 1'b1;
        check("t2_full_ready", {63'd0, pc_ready}, 64'd0);
        check("t2_head", {instr_pc, instr}, {32'h4, 32'h1111_1111});
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        check("t2_ready_after_pop", {63'd0, pc_ready}, 64'd1);
        do_fetch(32'hC, 32'h3333_3333, 0, 1'b1);
        instr_ready = 1'b1;
        repeat (3) tick();
        instr_ready = 1'b0;
        check("t2_drained", {63'd0, instr_valid}, 64'd0);

        // ---- 3: misaligned pc ----
        pc = 32'h6;
        pc_valid = 1'b1;
        check("t3_ready", {63'd0, pc_ready}, 64'd1);
        tick();
        pc_valid = 1'b0;
        check("t3_misalign_hi", {63'd0, misalign}, 64'd1);
        check("t3_no_req", {63'd0, mem_req}, 64'd0);
        check("t3_ready_next", {63'd0, pc_ready}, 64'd1);
        tick();
        check("t3_misalign_lo", {63'd0, misalign}, 64'd0);
        check("t3_no_req2", {63'd0, mem_req}, 64'd0);

        // ---- 4: flush clears queue and discards in-flight data ----
        do_fetch(32'h30, 32'h3030_3030, 0, 1'b0);
        pc = 32'h10;
        pc_valid = 1'b1;
        tick();
        pc_valid = 1'b0;
        check("t4_req", {63'd0, mem_req}, 64'd1);
        flush = 1'b1;
        check("t4_flush_ready", {63'd0, pc_ready}, 64'd0);
        tick();
        flush = 1'b0;
        check("t4_flushed_empty", {63'd0, instr_valid}, 64'd0);
        check("t4_wait_ready", {63'd0, pc_ready}, 64'd0);
        tick();
        tick();
        mem_ack = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        tick();
        mem_ack = 1'b0;
        check("t4_no_push", {63'd0, instr_valid}, 64'd0);
        check("t4_ready_after_ack", {63'd0, pc_ready}, 64'd1);
        check("t4_req_low", {63'd0, mem_req}, 64'd0);

        // ---- 5: pop and ack together with one entry queued ----
        do_fetch(32'h40, 32'hAAAA_0040, 0, 1'b1);
        pc = 32'h44;
        pc_valid = 1'b1;
        tick();
        pc_valid = 1'b0;
        instr_ready = 1'b1;
        mem_ack = 1'b1;
        mem_rdata = 32'hBBBB_0044;
        exp_q.push_back({32'h44, 32'hBBBB_0044});
        tick();
        instr_ready = 1'b0;
        mem_ack = 1'b0;
        check("t5_valid", {63'd0, instr_valid}, 64'd1);
        check("t5_head", {instr_pc, instr}, {32'h44, 32'hBBBB_0044});
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        check("t5_count_was_1", {63'd0, instr_valid}, 64'd0);

        // ---- 6: reset mid-request, stray ack ignored ----
        pc = 32'h50;
        pc_valid = 1'b1;
        tick();
        pc_valid = 1'b0;
        check("t6_req", {63'd0, mem_req}, 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_req_cleared", {63'd0, mem_req}, 64'd0);
        check("t6_addr_cleared", {32'd0, mem_addr}, 64'd0);
        check("t6_ready", {63'd0, pc_ready}, 64'd1);
        mem_ack = 1'b1;
        mem_rdata = 32'h5555_5555;
        tick();
        mem_ack = 1'b0;
        check("t6_ack_ignored", {63'd0, instr_valid}, 64'd0);
        check("t6_req_still_low", {63'd0, mem_req}, 64'd0);

        tick();
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
